// File: rtl/controle_de_busca_if.sv
// Fetch-side bus of controle_de_busca: instruction-memory read port, decode
// handshake, redirect request and the sticky fault flag.
interface controle_de_busca_if;
  logic        habilita;
  logic [31:0] endereco_imem;
  logic [31:0] instrucao_imem;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic        erro;

  // The fetch unit itself
  modport slave (
    input  habilita, instrucao_imem, instr_ready, desvio, alvo_desvio,
    output endereco_imem, instr_out, pc_out, instr_valid, erro
  );

  // The surrounding core: memory, decode and branch resolution
  modport master (
    output habilita, instrucao_imem, instr_ready, desvio, alvo_desvio,
    input  endereco_imem, instr_out, pc_out, instr_valid, erro
  );
endinterface

// File: rtl/controle_de_busca.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational instruction
// memory and feeds decode through a small registered queue with redirect support.
module controle_de_busca #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 256,
  parameter int          QDEPTH     = 2
) (
  input logic clk,
  input logic reset,
  controle_de_busca_if.slave bus
);

  localparam int          CW      = $clog2(QDEPTH + 1);
  localparam int          IW      = $clog2(QDEPTH);
  localparam logic [31:0] LAST_PC = 32'(IMEM_WORDS * 4 - 4);

  typedef enum logic [1:0] {IDLE, BUSCA, FALHA} estado_t;

  estado_t      estado;
  logic [31:0]  pc;
  logic [CW-1:0] count;
  logic [31:0]  q_instr [QDEPTH];
  logic [31:0]  q_pc    [QDEPTH];
  logic         erro_r;

  logic          pop;
  logic          push;
  logic          alvo_invalido;
  logic          ultimo;
  logic [IW-1:0] wr_idx;

  // Entry 0 is always the head, so the outputs come straight from registers.
  assign bus.endereco_imem = pc;
  assign bus.instr_out     = q_instr[0];
  assign bus.pc_out        = q_pc[0];
  assign bus.instr_valid   = (count != '0);
  assign bus.erro          = erro_r;

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop           = (count != '0) && bus.instr_ready;
    push          = (estado == BUSCA) && bus.habilita && ((count < CW'(QDEPTH)) || pop);
    alvo_invalido = (bus.alvo_desvio[1:0] != 2'b00) || (bus.alvo_desvio > LAST_PC);
    ultimo        = (pc == LAST_PC);
    wr_idx        = pop ? IW'(count - 1'b1) : IW'(count);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= IDLE;
      pc     <= RESET_PC;
      count  <= '0;
      erro_r <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= 32'h0;
        q_pc[i]    <= 32'h0;
      end
    end else begin
      case (estado)
        FALHA: begin
          // Already-fetched words keep draining; nothing new enters.
          if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
              q_instr[i] <= q_instr[i+1];
              q_pc[i]    <= q_pc[i+1];
            end
            count <= count - 1'b1;
          end
        end
        default: begin
          if (bus.desvio) begin
            count <= '0;
            if (alvo_invalido) begin
              estado <= FALHA;
              erro_r <= 1'b1;
            end else begin
              pc <= bus.alvo_desvio;
              if ((estado == BUSCA) && !bus.habilita)
                estado <= IDLE;
            end
          end else begin
            if (pop) begin
              for (int i = 0; i < QDEPTH - 1; i++) begin
                q_instr[i] <= q_instr[i+1];
                q_pc[i]    <= q_pc[i+1];
              end
            end
            if (push) begin
              q_instr[wr_idx] <= bus.instrucao_imem;
              q_pc[wr_idx]    <= pc;
            end
            if (push && !pop)
              count <= count + 1'b1;
            else if (pop && !push)
              count <= count - 1'b1;

            // Fetching the last word parks the PC there instead of stepping past memory.
            if (push && ultimo) begin
              estado <= FALHA;
              erro_r <= 1'b1;
            end else begin
              if (push)
                pc <= pc + 32'd4;
              estado <= bus.habilita ? BUSCA : IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_de_busca.sv
// Directed bench for controle_de_busca against a small program in a
// combinational instruction memory model.
module tb_controle_de_busca;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [31:0] mem [256];
  logic [31:0] prog [4];

  controle_de_busca_if bus();

  controle_de_busca dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instrucao_imem = mem[bus.endereco_imem[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic hab, input logic rdy, input logic dsv, input logic [31:0] alvo);
    bus.habilita    = hab;
    bus.instr_ready = rdy;
    bus.desvio      = dsv;
    bus.alvo_desvio = alvo;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    prog[0] = 32'h20080001;
    prog[1] = 32'h20090002;
    prog[2] = 32'h01095020;
    prog[3] = 32'hAC0A0000;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];

    // Reset values
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rst_instr", bus.instr_out, 32'h0);
    checkOutput("rst_pc_out", bus.pc_out, 32'h0);
    checkOutput("rst_erro", {31'b0, bus.erro}, 32'h0);
    checkOutput("rst_addr", bus.endereco_imem, 32'h0);

    // Streaming fetch with decode always ready
    $display("[TB] streaming fetch");
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("s_start_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("s_start_addr", bus.endereco_imem, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("s_valid", {31'b0, bus.instr_valid}, 32'h1);
      checkOutput("s_instr", bus.instr_out, prog[i]);
      checkOutput("s_pc", bus.pc_out, 32'(i * 4));
    end

    // Back-pressure: queue fills to two entries and PC holds
    $display("[TB] back-pressure");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_addr", bus.endereco_imem, 32'h8);
      checkOutput("bp_instr", bus.instr_out, prog[0]);
      checkOutput("bp_valid", {31'b0, bus.instr_valid}, 32'h1);
    end
    bus.instr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      checkOutput("bp_resume_instr", bus.instr_out, prog[i]);
      checkOutput("bp_resume_pc", bus.pc_out, 32'(i * 4));
      checkOutput("bp_resume_valid", {31'b0, bus.instr_valid}, 32'h1);
    end

    // Redirect with a full queue
    $display("[TB] redirect");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8);
    tick();
    checkOutput("rd_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rd_addr", bus.endereco_imem, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("rd_tgt_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("rd_tgt_instr", bus.instr_out, prog[2]);
    checkOutput("rd_tgt_pc", bus.pc_out, 32'h8);

    // Misaligned redirect target faults; desvio in fault state is ignored
    $display("[TB] misaligned target");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h6);
    tick();
    checkOutput("mis_erro", {31'b0, bus.erro}, 32'h1);
    checkOutput("mis_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("mis_addr", bus.endereco_imem, 32'hC);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, (i == 5), 32'h0);
      tick();
      checkOutput("mis_hold_erro", {31'b0, bus.erro}, 32'h1);
      checkOutput("mis_hold_valid", {31'b0, bus.instr_valid}, 32'h0);
      checkOutput("mis_hold_addr", bus.endereco_imem, 32'hC);
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("mis_rst_erro", {31'b0, bus.erro}, 32'h0);
    checkOutput("mis_rst_addr", bus.endereco_imem, 32'h0);

    // Redirect while idle, then an out-of-range target
    $display("[TB] idle redirect and range fault");
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10);
    tick();
    checkOutput("idle_rd_addr", bus.endereco_imem, 32'h10);
    checkOutput("idle_rd_erro", {31'b0, bus.erro}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("idle_hold_addr", bus.endereco_imem, 32'h10);
    checkOutput("idle_hold_valid", {31'b0, bus.instr_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h400);
    tick();
    checkOutput("range_erro", {31'b0, bus.erro}, 32'h1);
    checkOutput("range_addr", bus.endereco_imem, 32'h10);

    // Sequential run off the end of memory
    $display("[TB] end of memory");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h3F8);
    tick();
    checkOutput("end_rd_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("end_rd_addr", bus.endereco_imem, 32'h3F8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("end_w0_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("end_w0_instr", bus.instr_out, 32'h0);
    checkOutput("end_w0_pc", bus.pc_out, 32'h3F8);
    checkOutput("end_w0_erro", {31'b0, bus.erro}, 32'h0);
    tick();
    checkOutput("end_w1_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("end_w1_pc", bus.pc_out, 32'h3FC);
    checkOutput("end_w1_erro", {31'b0, bus.erro}, 32'h1);
    tick();
    checkOutput("end_drain_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("end_drain_erro", {31'b0, bus.erro}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("end_addr_park", bus.endereco_imem, 32'h3FC);
    end

    // Reset overrides a simultaneous redirect with a full queue
    $display("[TB] reset with redirect");
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("r6_full_valid", {31'b0, bus.instr_valid}, 32'h1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8);
    tick();
    checkOutput("r6_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("r6_addr", bus.endereco_imem, 32'h0);
    checkOutput("r6_erro", {31'b0, bus.erro}, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("r6_idle_valid", {31'b0, bus.instr_valid}, 32'h0);
      checkOutput("r6_idle_addr", bus.endereco_imem, 32'h0);
    end
    bus.habilita = 1'b1;
    tick();
    checkOutput("r6_go_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    checkOutput("r6_first_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("r6_first_instr", bus.instr_out, prog[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
